// File: rtl/rp_mult_core.sv
// rp_mult_core: unsigned Russian-peasant (shift-and-add) multiplier with
// valid/ready handshakes on both the operand and the product side.
// One partial-product step is taken per clock while in RUN.
// Optional macro RP_EARLY_TERM_EN: stop as soon as the remaining multiplier
// bits are all zero instead of always running WIDTH steps.
module rp_mult_core #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic [PW-1:0]   a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [PW-1:0]   acc_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   product_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;
    logic            busy_reg;

    logic [PW-1:0]    addend;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] b_next;
    logic [CW-1:0]    cnt_next;
    logic             last_step;

    // Partial product for this step: the shifted multiplicand gated by the
    // current low multiplier bit.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_addend
            assign addend[gi] = a_reg[gi] & b_reg[0];
        end
    endgenerate

    assign acc_next = acc_reg + addend;
    assign b_next   = b_reg >> 1;
    assign cnt_next = cnt_reg + CW'(1);

`ifdef RP_EARLY_TERM_EN
    // Finished once no multiplier bits remain; a zero multiplier still takes
    // one step because the check looks at the value after the step.
    assign last_step = (b_next == '0);
`else
    // Fixed schedule: exactly WIDTH steps for every operand pair.
    assign last_step = (cnt_next == CW'(WIDTH));
`endif

    // Control FSM and datapath; all handshake outputs are registered flags
    // updated together with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            product_reg   <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= {{WIDTH{1'b0}}, a};
                        b_reg        <= b;
                        acc_reg      <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= RUN;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    a_reg   <= a_reg << 1;
                    b_reg   <= b_next;
                    cnt_reg <= cnt_next;
                    if (last_step) begin
                        // Product is captured from the final accumulation so
                        // it is valid in the very first DONE cycle.
                        product_reg   <= acc_next;
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE here (not accepting directly) keeps a
                    // consume and a new accept in separate cycles.
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign product   = product_reg;

endmodule

// File: tb/tb_rp_mult_core.sv
// tb_rp_mult_core: table-driven directed transactions, hold/reset corner
// sequences and a random back-to-back stream against an arithmetic model.
// Set RP_EARLY_TERM_EN to match the build of the design under test.
module tb_rp_mult_core;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [2*W-1:0] product;
    logic          busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    rp_mult_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        int             n_early;
    } vec_t;

    vec_t vecs[6];

    // Reference: plain wide multiplication.
    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xx;
        logic [2*W-1:0] yy;
        xx = {{W{1'b0}}, x};
        yy = {{W{1'b0}}, y};
        return xx * yy;
    endfunction

    // Reference step count for the configuration being built.
    function automatic int model_steps(input int n_early);
`ifdef RP_EARLY_TERM_EN
        return n_early;
`else
        return (n_early >= 0) ? W : W;
`endif
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One full transaction: accept, count steps, check result, consume.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic [2*W-1:0] exp_p, input int exp_n, input string tag);
        int k;
        logic [2*W-1:0] got;
        check({tag, "_ready"}, {63'b0, in_ready}, 64'd1);
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = $urandom; b = $urandom;
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_steps"}, 64'(k), 64'(exp_n));
        check({tag, "_product"}, product, exp_p);
        check({tag, "_busy_done"}, {63'b0, busy}, 64'd1);
        check({tag, "_inready_done"}, {63'b0, in_ready}, 64'd0);
        got = product;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_after"}, {63'b0, out_valid}, 64'd0);
        check({tag, "_idle_busy"}, {63'b0, busy}, 64'd0);
        check({tag, "_retain"}, product, got);
        $display("txn %s: a=%0h b=%0h product=%0h steps=%0d", tag, ta, tb, got, k);
    endtask

    initial begin
        logic [2*W-1:0] expq[$];
        logic [2*W-1:0] e;
        int consumed;
        int cyc;
        int k;
        bit ov_seen;

        vecs[0] = '{a: 32'd6,          b: 32'd7,          prod: 64'd42,                  n_early: 3};
        vecs[1] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  prod: 64'hFFFF_FFFE_0000_0001, n_early: 32};
        vecs[2] = '{a: 32'd5,          b: 32'd0,          prod: 64'd0,                   n_early: 1};
        vecs[3] = '{a: 32'd1,          b: 32'd1,          prod: 64'd1,                   n_early: 1};
        vecs[4] = '{a: 32'h8000_0000,  b: 32'd2,          prod: 64'h1_0000_0000,         n_early: 2};
        vecs[5] = '{a: 32'hFFFF_FFFF,  b: 32'h8000_0000,  prod: 64'h7FFF_FFFF_8000_0000, n_early: 32};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_product", product, 64'd0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].a, vecs[i].b, vecs[i].prod, model_steps(vecs[i].n_early), $sformatf("vec%0d", i));
        end

        // Product, out_valid and in_ready hold while out_ready is low.
        a = 32'd6; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("hold_reached", {63'b0, out_valid}, 64'd1);
        in_valid = 1'b1; a = 32'd3; b = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_product", product, 64'd42);
            check("hold_out_valid", {63'b0, out_valid}, 64'd1);
            check("hold_in_ready", {63'b0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hold_release_ready", {63'b0, in_ready}, 64'd1);
        check("hold_release_ov", {63'b0, out_valid}, 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_next_accept", {63'b0, busy}, 64'd1);
        k = 0;
        while (!out_valid && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        check("hold_next_product", product, 64'd12);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("txn hold: 6*7 held 5 cycles, then 3*4 product=%0h", product);

        // Reset on the second RUN cycle discards the operation.
        a = 32'd6; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_product", product, 64'd0);
        ov_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("midrst_no_ov", {63'b0, ov_seen}, 64'd0);
        run_txn(32'd3, 32'd4, 64'd12, model_steps(3), "after_rst");

        // Random back-to-back stream with random consumer back-pressure.
        consumed = 0; cyc = 0;
        in_valid = 1'b1;
        while (consumed < 1000 && cyc < 90000) begin
            a = $urandom >> $urandom_range(0, 32);
            b = $urandom >> $urandom_range(0, 32);
            out_ready = 1'($urandom_range(0, 1));
            if (in_ready) expq.push_back(model_prod(a, b));
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    check("stream_unexpected", product, 64'hDEAD);
                end else begin
                    e = expq.pop_front();
                    check("stream_product", product, e);
                end
                consumed++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("stream_count", 64'(consumed), 64'd1000);
        check("stream_queue_empty", 64'(expq.size()), 64'd0);
        $display("txn stream: consumed=%0d cycles=%0d", consumed, cyc);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
